// File: rtl/maze_pkg.sv
// Shared maze/route constants, direction encodings and sequencer state type.
package maze_pkg;

  localparam int unsigned GRID_SIZE    = 10;
  localparam int unsigned MAX_PATH_DEF = GRID_SIZE * GRID_SIZE;
  localparam int unsigned PATH_IDX_W   = 7;
  localparam int unsigned DIR_W        = 4;

  localparam logic [DIR_W-1:0] DIR_UP    = 4'b0001;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0010;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b0100;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_TRACE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_PLAY    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // A move is legal only when it is exactly one of the four directions.
  function automatic logic is_onehot(input logic [DIR_W-1:0] d);
    return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

endpackage

// File: rtl/route_sequencer_if.sv
// Search / backtrace / path-write / rover-move signals of the route sequencer.
interface route_sequencer_if;
  import maze_pkg::*;

  logic                  search_start;
  logic                  search_done;
  logic                  search_fail;
  logic                  backtrace_en;
  logic                  backtrace_done;
  logic                  path_write_en;
  logic [PATH_IDX_W-1:0] path_write_index;
  logic [DIR_W-1:0]      path_write_data;
  logic [PATH_IDX_W-1:0] path_length;
  logic                  move_valid;
  logic                  move_ready;
  logic [DIR_W-1:0]      move_dir;

  modport master (
    output search_start, backtrace_en, move_valid, move_dir,
    input  search_done, search_fail, backtrace_done, path_write_en,
    input  path_write_index, path_write_data, path_length, move_ready
  );

  modport slave (
    input  search_start, backtrace_en, move_valid, move_dir,
    output search_done, search_fail, backtrace_done, path_write_en,
    output path_write_index, path_write_data, path_length, move_ready
  );

endinterface

// File: rtl/path_buffer.sv
// Path move storage: one synchronous write port, one asynchronous read port.
module path_buffer
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_PATH_DEF
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [PATH_IDX_W-1:0] i_wr_addr,
  input  logic [DIR_W-1:0]      i_wr_data,
  input  logic [PATH_IDX_W-1:0] i_rd_addr,
  output logic [DIR_W-1:0]      o_rd_data_c
);

  logic [DIR_W-1:0] r_mem [DEPTH];

  // Store a move; contents intentionally survive reset and runs.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Out-of-range lookahead reads (one past the last move) return zero.
  assign o_rd_data_c = (i_rd_addr < PATH_IDX_W'(DEPTH)) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/route_sequencer.sv
// Sequences A* search, path backtrace into a buffer, and move playback to the rover.
module route_sequencer
  import maze_pkg::*;
#(
  parameter int unsigned MAX_PATH   = MAX_PATH_DEF,
  parameter int unsigned BT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  route_sequencer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned           TO_W    = $clog2(BT_TIMEOUT + 1);
  localparam logic [PATH_IDX_W-1:0] MAX_LEN = PATH_IDX_W'(MAX_PATH);
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(BT_TIMEOUT - 1);

  state_t                r_state;
  logic                  r_search_start;
  logic                  r_backtrace_en;
  logic                  r_move_valid;
  logic [DIR_W-1:0]      r_move_dir;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [PATH_IDX_W-1:0] r_cnt;
  logic [PATH_IDX_W-1:0] r_len;
  logic [TO_W-1:0]       r_timeout;

  logic                  w_wr_ok;
  logic                  w_bad_write;
  logic                  w_wr_en;
  logic [PATH_IDX_W-1:0] w_rd_addr;
  logic [DIR_W-1:0]      w_rd_data;

  assign w_wr_ok     = (bus.path_write_index < MAX_LEN) && is_onehot(bus.path_write_data);
  assign w_bad_write = bus.path_write_en && !w_wr_ok;
  assign w_wr_en     = (r_state == ST_TRACE) && bus.path_write_en && w_wr_ok && !abort;
  // In PLAY look one entry ahead so the next move is ready at the handshake.
  assign w_rd_addr   = (r_state == ST_PLAY) ? r_cnt + PATH_IDX_W'(1) : r_cnt;

  path_buffer #(.DEPTH(MAX_PATH)) u_path_buffer (
    .clk         (clk),
    .i_wr_en     (w_wr_en),
    .i_wr_addr   (bus.path_write_index),
    .i_wr_data   (bus.path_write_data),
    .i_rd_addr   (w_rd_addr),
    .o_rd_data_c (w_rd_data)
  );

  // Run-control state machine with registered outputs; abort overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_search_start <= 1'b0;
      r_backtrace_en <= 1'b0;
      r_move_valid   <= 1'b0;
      r_move_dir     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cnt          <= '0;
      r_len          <= '0;
      r_timeout      <= '0;
    end else begin
      r_search_start <= 1'b0;
      r_done         <= 1'b0;
      if (abort) begin
        r_state        <= ST_IDLE;
        r_busy         <= 1'b0;
        r_backtrace_en <= 1'b0;
        r_move_valid   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state        <= ST_SEARCH;
              r_search_start <= 1'b1;
              r_busy         <= 1'b1;
              r_error        <= 1'b0;
              r_cnt          <= '0;
            end
          end
          ST_SEARCH: begin
            if (bus.search_done) begin
              if (bus.search_fail) begin
                r_state <= ST_ERROR;
                r_error <= 1'b1;
              end else begin
                r_state        <= ST_TRACE;
                r_backtrace_en <= 1'b1;
                r_timeout      <= '0;
              end
            end
          end
          ST_TRACE: begin
            r_timeout <= r_timeout + TO_W'(1);
            if (w_bad_write) begin
              r_state        <= ST_ERROR;
              r_backtrace_en <= 1'b0;
              r_error        <= 1'b1;
            end else if (bus.backtrace_done) begin
              r_len          <= bus.path_length;
              r_backtrace_en <= 1'b0;
              if (bus.path_length > MAX_LEN) begin
                r_state <= ST_ERROR;
                r_error <= 1'b1;
              end else begin
                r_state <= ST_RELEASE;
              end
            end else if (r_timeout == TO_LAST) begin
              r_state        <= ST_ERROR;
              r_backtrace_en <= 1'b0;
              r_error        <= 1'b1;
            end
          end
          ST_RELEASE: begin
            if (!bus.backtrace_done) begin
              if (r_len == '0) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state      <= ST_PLAY;
                r_move_valid <= 1'b1;
                r_move_dir   <= w_rd_data;
              end
            end
          end
          ST_PLAY: begin
            if (bus.move_ready) begin
              if (r_cnt == r_len - PATH_IDX_W'(1)) begin
                r_state      <= ST_IDLE;
                r_move_valid <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
              end else begin
                r_cnt      <= r_cnt + PATH_IDX_W'(1);
                r_move_dir <= w_rd_data;
              end
            end
          end
          ST_ERROR: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.search_start = r_search_start;
  assign bus.backtrace_en = r_backtrace_en;
  assign bus.move_valid   = r_move_valid;
  assign bus.move_dir     = r_move_dir;
  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;

endmodule
